// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle between a client and serial_add_ctrl
`timescale 1ns/1ps
//
// Purpose: groups the operation request (start, a, b, cin) and the result
// (busy, done, sum, cout and, when SERIAL_ADD_OVF_EN is defined, ovf).
//
// Signals:
//   start  client -> ctrl  request, only honoured while the controller is idle
//   a, b   client -> ctrl  WIDTH-bit operands, captured on an accepted start
//   cin    client -> ctrl  carry-in, captured on an accepted start
//   busy   ctrl -> client  high from the cycle after accept through the done cycle
//   done   ctrl -> client  one-cycle pulse, result valid
//   sum    ctrl -> client  WIDTH-bit result, held until the next accepted start
//   cout   ctrl -> client  final carry, held with sum
//   ovf    ctrl -> client  signed overflow (only with SERIAL_ADD_OVF_EN)
//
// Modports: master = client side, slave = controller side.

interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_ADD_OVF_EN
        input  ovf,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_ADD_OVF_EN
        output ovf,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add controller around an external delayed full adder
`timescale 1ns/1ps
//
// Purpose: captures two WIDTH-bit operands and a carry-in, then presents one
// bit pair plus the running carry to an external gate-level full adder per
// step. Each step is held for SETTLE clocks so the adder's gate delays can
// resolve before Sum/Cout are sampled into the result shift register.
//
// Parameters:
//   WIDTH   operand/result width (>= 2)
//   SETTLE  clocks each bit is held on the adder before sampling (>= 1)
//
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
// output io.ovf (carry into MSB xor carry out of MSB).
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   io       request/result bundle (slave side of serial_add_ctrl_if)
//   fa_a     to full adder A      (registered)
//   fa_b     to full adder B      (registered)
//   fa_cin   to full adder Cin    (registered; also the running carry)
//   fa_sum   from full adder Sum
//   fa_cout  from full adder Cout

module serial_add_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 3
) (
    input  logic              clk,
    input  logic              reset,
    serial_add_ctrl_if.slave  io,
    output logic              fa_a,
    output logic              fa_b,
    output logic              fa_cin,
    input  logic              fa_sum,
    input  logic              fa_cout
);

    localparam int BW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;

    // a_r/b_r hold only the bits not yet presented to the adder: the bit
    // currently on the adder lives in fa_a/fa_b, so the next one is a_r[0].
    logic [WIDTH-2:0] a_r;
    logic [WIDTH-2:0] b_r;
    // Samples taken so far, MSB-aligned; the final sample completes the word.
    logic [WIDTH-2:0] s_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic [BW-1:0]    bit_cnt;
    logic [SW-1:0]    settle_cnt;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_r;
`endif

    logic [WIDTH-1:0] s_next;

    assign s_next = {fa_sum, s_r};

    // fa_cin doubles as the carry register: it always holds the carry into
    // the bit currently on the adder, so no separate copy is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            s_r        <= '0;
            sum_r      <= '0;
            cout_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            fa_a       <= 1'b0;
            fa_b       <= 1'b0;
            fa_cin     <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r      <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        a_r        <= io.a[WIDTH-1:1];
                        b_r        <= io.b[WIDTH-1:1];
                        fa_a       <= io.a[0];
                        fa_b       <= io.b[0];
                        fa_cin     <= io.cin;
                        s_r        <= '0;
                        sum_r      <= '0;
                        cout_r     <= 1'b0;
                        bit_cnt    <= '0;
                        settle_cnt <= '0;
                        busy_r     <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_r      <= 1'b0;
`endif
                        state      <= RUN;
                    end
                end

                RUN: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        bit_cnt    <= bit_cnt + 1'b1;
                        s_r        <= s_next[WIDTH-1:1];
                        if (bit_cnt == BIT_LAST) begin
                            // MSB sample: publish the result; adder inputs
                            // keep their last values while idle.
                            sum_r  <= s_next;
                            cout_r <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                            ovf_r  <= fa_cin ^ fa_cout;
`endif
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            fa_a   <= a_r[0];
                            fa_b   <= b_r[0];
                            fa_cin <= fa_cout;
                            a_r    <= a_r >> 1;
                            b_r    <= b_r >> 1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign io.busy = busy_r;
    assign io.done = done_r;
    assign io.sum  = sum_r;
    assign io.cout = cout_r;
`ifdef SERIAL_ADD_OVF_EN
    assign io.ovf  = ovf_r;
`endif

endmodule
